// File: rtl/entropy_decoder_pkg.sv
// entropy_decoder_pkg: shared widths, window reset constant and refill FSM states.
package entropy_decoder_pkg;
    localparam int IN_WIDTH     = 16;
    localparam int WINDOW_WIDTH = 32;
    localparam int FILL_WIDTH   = 6;
    localparam int D_SIZE       = 4;
    localparam logic [WINDOW_WIDTH-1:0] WINDOW_ONES = '1;
    typedef enum logic [1:0] {FILL, RUN, EOS} state_t;
endpackage

// File: rtl/refill_merge.sv
// refill_merge: XORs an incoming bitstream word into the complemented window below the valid bits.
module refill_merge
    import entropy_decoder_pkg::*;
(
    input  logic [WINDOW_WIDTH-1:0] window,
    input  logic [FILL_WIDTH-1:0]   fill,
    input  logic [IN_WIDTH-1:0]     word,
    input  logic                    half,
    output logic [WINDOW_WIDTH-1:0] merged,
    output logic [FILL_WIDTH-1:0]   merged_fill
);
    logic [IN_WIDTH-1:0] data;
    // a half word only carries its upper byte; the low byte is treated as zero data
    assign data        = half ? {word[IN_WIDTH-1:IN_WIDTH/2], {(IN_WIDTH/2){1'b0}}} : word;
    assign merged      = window ^ ({data, {IN_WIDTH{1'b0}}} >> fill);
    assign merged_fill = fill + (half ? FILL_WIDTH'(IN_WIDTH/2) : FILL_WIDTH'(IN_WIDTH));
endmodule

// File: rtl/bitstream_refill.sv
// bitstream_refill: maintains the decoder dif window, applies normalization shifts and refills from 16-bit words.
// Optional REFILL_TELL_EN adds out_tell, the running count of consumed bits.
module bitstream_refill
    import entropy_decoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     in_word,
    input  logic                    in_last,
    input  logic                    in_half,
    output logic                    out_valid,
    output logic [WINDOW_WIDTH-1:0] out_window,
    output logic [FILL_WIDTH-1:0]   out_fill,
    output logic                    out_eos,
    input  logic                    upd_valid,
    input  logic [WINDOW_WIDTH-1:0] upd_window,
    input  logic [D_SIZE-1:0]       upd_d
`ifdef REFILL_TELL_EN
    ,
    output logic [31:0]             out_tell
`endif
);
    state_t state, state_nx;
    logic upd_acc, accept;
    logic [WINDOW_WIDTH-1:0] w_upd, merged, window_nx;
    logic [FILL_WIDTH-1:0] f_upd, merged_fill, fill_nx;

    refill_merge u_merge (
        .window      (w_upd),
        .fill        (f_upd),
        .word        (in_word),
        .half        (in_half && in_last),
        .merged      (merged),
        .merged_fill (merged_fill)
    );

    always_comb begin
        out_valid = state != FILL;
        out_eos   = state == EOS;
        in_ready  = !in_start && state != EOS && out_fill <= FILL_WIDTH'(IN_WIDTH);
        upd_acc   = upd_valid && out_valid && !in_start;
        accept    = in_valid && in_ready;
        // complemented window: shifting in ones is shifting in zero data
        w_upd     = upd_acc ? ((upd_window + WINDOW_WIDTH'(1)) << upd_d) - WINDOW_WIDTH'(1) : out_window;
        f_upd     = !upd_acc ? out_fill :
                    out_fill >= FILL_WIDTH'(upd_d) ? out_fill - FILL_WIDTH'(upd_d) : '0;
        window_nx = accept ? merged : w_upd;
        fill_nx   = accept ? merged_fill : f_upd;
        state_nx  = (accept && in_last) || state == EOS ? EOS :
                    fill_nx >= FILL_WIDTH'(IN_WIDTH) ? RUN : FILL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        state <= FILL;
        else if (in_start) state <= FILL;
        else               state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_window <= WINDOW_ONES;
            out_fill   <= '0;
        end else if (in_start) begin
            out_window <= WINDOW_ONES;
            out_fill   <= '0;
        end else begin
            out_window <= window_nx;
            out_fill   <= fill_nx;
        end
    end

`ifdef REFILL_TELL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        out_tell <= '0;
        else if (in_start) out_tell <= '0;
        else if (upd_acc)  out_tell <= out_tell + 32'(upd_d);
    end
`endif
endmodule

// File: tb/tb_bitstream_refill.sv
// tb_bitstream_refill: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_bitstream_refill;
    import entropy_decoder_pkg::*;

    logic        clk = 0, reset = 0, in_start = 0, in_valid = 0, in_last = 0, in_half = 0, upd_valid = 0;
    logic [15:0] in_word = '0;
    logic [31:0] upd_window = '0;
    logic [3:0]  upd_d = '0;
    logic        in_ready, out_valid, out_eos;
    logic [31:0] out_window;
    logic [5:0]  out_fill;
`ifdef REFILL_TELL_EN
    logic [31:0] out_tell;
`endif

    typedef struct {
        string       name;
        logic [31:0] window;
        logic [5:0]  fill;
        logic        valid, eos, ready;
        logic [31:0] tell;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    bitstream_refill dut (
        .clk(clk), .reset(reset), .in_start(in_start), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_last(in_last), .in_half(in_half), .out_valid(out_valid),
        .out_window(out_window), .out_fill(out_fill), .out_eos(out_eos), .upd_valid(upd_valid),
        .upd_window(upd_window), .upd_d(upd_d)
`ifdef REFILL_TELL_EN
        , .out_tell(out_tell)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual %h required %h", n, f, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "window", out_window, e.window);
                chk(e.name, "fill", 32'(out_fill), 32'(e.fill));
                chk(e.name, "valid", 32'(out_valid), 32'(e.valid));
                chk(e.name, "eos", 32'(out_eos), 32'(e.eos));
                chk(e.name, "ready", 32'(in_ready), 32'(e.ready));
`ifdef REFILL_TELL_EN
                chk(e.name, "tell", out_tell, e.tell);
`endif
            end
        end
    end

    task automatic push(input string n, input logic [31:0] w, input logic [5:0] f,
                        input logic v, input logic eo, input logic r, input logic [31:0] t);
        exp_t e;
        e.name = n; e.window = w; e.fill = f; e.valid = v; e.eos = eo; e.ready = r; e.tell = t;
        q.push_back(e);
    endtask

    task automatic step(input string n, input logic st, input logic iv, input logic [15:0] wd,
                        input logic la, input logic ha, input logic uv, input logic [31:0] uw,
                        input logic [3:0] d, input logic [31:0] ew, input logic [5:0] ef,
                        input logic ev, input logic ee, input logic er, input logic [31:0] et);
        @(negedge clk);
        in_start = st; in_valid = iv; in_word = wd; in_last = la; in_half = ha;
        upd_valid = uv; upd_window = uw; upd_d = d;
        @(posedge clk);
        #1;
        in_start = 0; in_valid = 0; in_last = 0; in_half = 0; upd_valid = 0;
        push(n, ew, ef, ev, ee, er, et);
    endtask

    initial begin
        #12;
        push("reset", 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
        @(negedge clk);
        reset = 1;
        //    name        st iv word     la ha uv upd_window    d   exp_window    fill v  e  r  tell
        step("word1",     0, 1, 16'hA5C3, 0, 0, 0, 32'h0,        0, 32'h5A3C_FFFF, 16, 1, 0, 1, 0);
        step("word2",     0, 1, 16'h0F0F, 0, 0, 0, 32'h0,        0, 32'h5A3C_F0F0, 32, 1, 0, 0, 0);
        step("upd4",      0, 0, 16'h0,    0, 0, 1, 32'h5A3C_F0F0, 4, 32'hA3CF_0F0F, 28, 1, 0, 0, 4);
        step("upd12",     0, 0, 16'h0,    0, 0, 1, 32'hA3CF_0F0F,12, 32'hF0F0_FFFF, 16, 1, 0, 1, 16);
        step("upd15word", 0, 1, 16'h1234, 0, 0, 1, 32'hF0F0_FFFF,15, 32'h76E5_FFFF, 17, 1, 0, 0, 31);
        step("upd1",      0, 0, 16'h0,    0, 0, 1, 32'h76E5_FFFF, 1, 32'hEDCB_FFFF, 16, 1, 0, 1, 32);
        step("lasthalf",  0, 1, 16'hAB00, 1, 1, 0, 32'h0,        0, 32'hEDCB_54FF, 24, 1, 1, 0, 32);
        step("eos_upd1",  0, 0, 16'h0,    0, 0, 1, 32'hEDCB_54FF,15, 32'hAA7F_FFFF,  9, 1, 1, 0, 47);
        step("eos_upd2",  0, 0, 16'h0,    0, 0, 1, 32'hAA7F_FFFF,15, 32'hFFFF_FFFF,  0, 1, 1, 0, 62);
        step("eos_upd3",  0, 1, 16'hFFFF, 0, 0, 1, 32'hFFFF_FFFF,15, 32'hFFFF_FFFF,  0, 1, 1, 0, 77);
        step("start",     1, 1, 16'h1111, 0, 0, 1, 32'h0,        3, 32'hFFFF_FFFF,  0, 0, 0, 1, 0);
        step("word3",     0, 1, 16'h8001, 0, 0, 0, 32'h0,        0, 32'h7FFE_FFFF, 16, 1, 0, 1, 0);
        step("bubble",    0, 0, 16'h0,    0, 0, 1, 32'h7FFE_FFFF, 4, 32'hFFEF_FFFF, 12, 0, 0, 1, 4);
        @(negedge clk);
        #1;
        reset = 0;
        push("async_rst", 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
        @(negedge clk);
        reset = 1;
        step("half_nolast", 0, 1, 16'h00FF, 0, 1, 0, 32'h0,      0, 32'hFF00_FFFF, 16, 1, 0, 1, 0);
        step("upd_to15",  0, 0, 16'h0,    0, 0, 1, 32'hFF00_FFFF, 1, 32'hFE01_FFFF, 15, 0, 0, 1, 1);
        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d required 0 pending", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
